posit_result_fifo: RTL and testbench
====================================

POSIT_RESULT_FIFO -- requirements
Module: posit_result_fifo

Interface
REQ-001 Parameter N, default 10, posit word width; matches the posit multiplier output width.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 in_valid  input  1  upstream multiplier result is valid this cycle.
REQ-006 in_data  input  N  posit product word in two's-complement sign form.
REQ-007 in_pinf  input  1  upstream infinity flag for in_data.
REQ-008 in_pzero  input  1  upstream zero flag for in_data.
REQ-009 in_ready  output  1  FIFO can accept a word this cycle; high when count < DEPTH.
REQ-010 out_valid  output  1  head entry is valid; high when count > 0.
REQ-011 out_ready  input  1  consumer takes head entry this cycle.
REQ-012 out_data  output  N  head entry posit word.
REQ-013 out_pinf  output  1  head entry infinity flag.
REQ-014 out_pzero  output  1  head entry zero flag.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 ovf  output  1  sticky flag: a valid word arrived while full and was dropped.
REQ-017 inf_cnt  output  8  number of accepted words with in_pinf=1.
REQ-018 zero_cnt  output  8  number of accepted words with in_pzero=1.

Function
REQ-019 Storage holds {in_pinf, in_pzero, in_data}, N+2 bits per entry, in circular buffer with write pointer, read pointer and occupancy counter.
REQ-020 Push occurs when in_valid=1 and in_ready=1; entry written at write pointer, pointer advances by one modulo DEPTH.
REQ-021 Pop occurs when out_valid=1 and out_ready=1; read pointer advances by one modulo DEPTH.
REQ-022 Outputs out_data/out_pinf/out_pzero are combinational reads of entry at read pointer; a word pushed into an empty FIFO is visible on out_* one cycle after the push edge (first-word latency 1 cycle).
REQ-023 Simultaneous push and pop: both pointers advance, count unchanged; legal at any occupancy 1..DEPTH-1, and at count=DEPTH only the pop proceeds (in_ready is low, no push).
REQ-024 Push at count=0 with out_ready=1 does not bypass; out_valid rises the following cycle.
REQ-025 in_valid=1 with in_ready=0: word discarded, storage and pointers unchanged, ovf set to 1 on that edge and held until reset.
REQ-026 out_ready with out_valid=0: no effect; count never underflows.
REQ-027 out_* hold their value while out_valid=1 and out_ready=0.
REQ-028 Pointer wrap from DEPTH-1 to 0 is seamless; ordering is strictly first-in first-out across wrap.
REQ-029 Flags are stored verbatim; the FIFO does not re-derive or check pinf/pzero against in_data.

Reset
REQ-030 reset=0 on a clock edge clears pointers, count=0, ovf=0, inf_cnt=0, zero_cnt=0; out_valid=0, in_ready=1 afterward.
REQ-031 Reset mid-operation discards all stored entries; no push or pop occurs on a reset edge regardless of handshakes.
REQ-032 Storage array is not reset; out_data/out_pinf/out_pzero are don't-care while out_valid=0.

Configuration
REQ-033 Macro PRF_STATS_EN: when defined, inf_cnt and zero_cnt increment by one on each accepted push carrying the respective flag, saturating at 255.
REQ-034 Without PRF_STATS_EN, inf_cnt and zero_cnt ports remain present and are tied to 0; no counter logic is built.

Verification
REQ-035 Reset, then push 10'h040, 10'h3C0, 10'h200 (pinf=1) on consecutive cycles with out_ready=0 -> count=3, in_ready=1, out_data=10'h040.
REQ-036 Fill DEPTH=4 with 1,2,3,4, then push 5 -> in_ready=0, ovf=1, count=4; drain -> outputs 1,2,3,4 in order, 5 never appears.
REQ-037 Continuous push and pop each cycle for 20 words 0..19 with out_ready=1 -> count stays at 1 after first cycle, all 20 words out in order across pointer wrap.
REQ-038 Push 3 words, assert reset=0 for one cycle while in_valid=1 and out_ready=1 -> count=0, out_valid=0, ovf=0 afterward; next push appears as head.
REQ-039 With PRF_STATS_EN, push 300 words with in_pinf=1 and 2 with in_pzero=1 (consumer always ready) -> inf_cnt=255, zero_cnt=2; without macro both read 0.
REQ-040 Pop attempts on empty FIFO (out_ready=1 for 5 cycles after reset) -> count stays 0, out_valid stays 0.

Source files
------------

// File: rtl/posit_result_fifo.sv
// -----------------------------------------------------------------------------
// posit_result_fifo
//
// Purpose:
//    Small circular-buffer FIFO that decouples a posit multiplier from its
//    consumer. Each entry holds {pinf, pzero, data} exactly as presented by the
//    producer; the flags are carried verbatim and never re-derived.
//    A word pushed into an empty FIFO appears on out_* one cycle after the push
//    edge (no bypass path). Words offered while full are dropped and latch the
//    sticky ovf flag.
//
// Parameters:
//    N      posit word width (default 10)
//    DEPTH  number of entries, power of two in 2..16 (default 4)
//
// Ports:
//    clk        sole clock, all state updates on the rising edge
//    reset      synchronous active-low reset
//    in_valid   producer word valid
//    in_data    producer posit word (N bits)
//    in_pinf    producer infinity flag
//    in_pzero   producer zero flag
//    in_ready   FIFO can accept a word (count < DEPTH)
//    out_valid  head entry valid (count > 0)
//    out_ready  consumer takes the head entry
//    out_data   head entry posit word
//    out_pinf   head entry infinity flag
//    out_pzero  head entry zero flag
//    count      occupancy 0..DEPTH
//    ovf        sticky: a valid word arrived while full and was dropped
//    inf_cnt    accepted words carrying pinf (saturating, stats build only)
//    zero_cnt   accepted words carrying pzero (saturating, stats build only)
//
// Build option:
//    PRF_STATS_EN  when defined, inf_cnt/zero_cnt count accepted flagged
//                  words and saturate at 255; otherwise both ports read 0
//                  and no counter logic exists.
// -----------------------------------------------------------------------------
module posit_result_fifo #(
   parameter int N     = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [N-1:0]             in_data,
   input  logic                     in_pinf,
   input  logic                     in_pzero,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_data,
   output logic                     out_pinf,
   output logic                     out_pzero,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic [7:0]               inf_cnt,
   output logic [7:0]               zero_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = N + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          push_s;
   logic          pop_s;
   logic [EW-1:0] head_s;

   // Handshake decode; ready/valid derive only from the registered occupancy
   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != {CW{1'b0}});
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;

   // Head entry is read combinationally; its value is meaningless while empty
   assign head_s    = mem_q[rd_ptr_q];
   assign out_pinf  = head_s[EW-1];
   assign out_pzero = head_s[EW-2];
   assign out_data  = head_s[N-1:0];

   assign count = count_q;
   assign ovf   = ovf_q;

   // Next-state for pointers, occupancy and the sticky overflow flag
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      // DEPTH is a power of two, so the natural PW-bit wrap is modulo DEPTH
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (in_valid && !in_ready) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; not reset, and a reset edge suppresses the write
   always_ff @(posedge clk) begin
      if (reset && push_s) begin
         mem_q[wr_ptr_q] <= {in_pinf, in_pzero, in_data};
      end
   end

`ifdef PRF_STATS_EN
   logic [7:0] inf_cnt_q, inf_cnt_d;
   logic [7:0] zero_cnt_q, zero_cnt_d;

   // Saturating counters of accepted words carrying each flag
   always_comb begin
      inf_cnt_d  = inf_cnt_q;
      zero_cnt_d = zero_cnt_q;

      if (push_s && in_pinf && (inf_cnt_q != 8'hFF)) begin
         inf_cnt_d = inf_cnt_q + 8'd1;
      end else begin
         inf_cnt_d = inf_cnt_q;
      end

      if (push_s && in_pzero && (zero_cnt_q != 8'hFF)) begin
         zero_cnt_d = zero_cnt_q + 8'd1;
      end else begin
         zero_cnt_d = zero_cnt_q;
      end
   end

   // Statistics register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         inf_cnt_q  <= 8'd0;
         zero_cnt_q <= 8'd0;
      end else begin
         inf_cnt_q  <= inf_cnt_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign inf_cnt  = inf_cnt_q;
   assign zero_cnt = zero_cnt_q;
`else
   assign inf_cnt  = 8'd0;
   assign zero_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_posit_result_fifo.sv
module tb_posit_result_fifo;

   localparam int N     = 10;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          in_pinf;
   logic          in_pzero;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;
   logic          out_pinf;
   logic          out_pzero;
   logic [2:0]    count;
   logic          ovf;
   logic [7:0]    inf_cnt;
   logic [7:0]    zero_cnt;

   int n_vec = 0;
   int n_err = 0;

   // expected entries, {pinf, pzero, data}
   logic [N+1:0] exp_q [$];

`ifdef PRF_STATS_EN
   localparam int EXP_INF  = 255;
   localparam int EXP_ZERO = 2;
`else
   localparam int EXP_INF  = 0;
   localparam int EXP_ZERO = 0;
`endif

   posit_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_pinf   (in_pinf),
      .in_pzero  (in_pzero),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_pinf  (out_pinf),
      .out_pzero (out_pzero),
      .count     (count),
      .ovf       (ovf),
      .inf_cnt   (inf_cnt),
      .zero_cnt  (zero_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: a pop happens on the next rising edge whenever valid & ready
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h expected no word at %0t",
                     {out_pinf, out_pzero, out_data}, $time);
         end else begin
            logic [N+1:0] e;
            e = exp_q.pop_front();
            if ({out_pinf, out_pzero, out_data} !== e) begin
               n_err++;
               $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t",
                        {out_pinf, out_pzero, out_data}, e, $time);
            end
         end
      end
   end

   // drive one cycle of push; records the expected entry when acceptance is expected
   task automatic push(input logic [N-1:0] d, input logic pi, input logic pz, input bit acc);
      in_valid = 1'b1;
      in_data  = d;
      in_pinf  = pi;
      in_pzero = pz;
      if (acc) exp_q.push_back({pi, pz, d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      idle(2);
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_pinf   = 1'b0;
      in_pzero  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_inf_cnt", 32'(inf_cnt), 32'd0);
      chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);

      // pops on an empty FIFO have no effect
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk("empty_pop_count", 32'(count), 32'd0);
         chk("empty_pop_valid", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;

      // three pushes with consumer stalled
      push(10'h040, 1'b0, 1'b0, 1'b1);
      chk("first_word_valid", 32'(out_valid), 32'd1);
      push(10'h3C0, 1'b0, 1'b0, 1'b1);
      push(10'h200, 1'b1, 1'b0, 1'b1);
      chk("three_count", 32'(count), 32'd3);
      chk("three_in_ready", 32'(in_ready), 32'd1);
      chk("three_head", 32'(out_data), 32'h040);
      out_ready = 1'b1;
      idle(3);
      out_ready = 1'b0;
      chk("three_drained", 32'(count), 32'd0);

      // fill, overflow, hold, drain
      for (int i = 1; i <= 4; i++) push(10'(i), 1'b0, 1'b0, 1'b1);
      chk("full_ovf_before", 32'(ovf), 32'd0);
      push(10'd5, 1'b0, 1'b0, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_ovf", 32'(ovf), 32'd1);
      chk("full_count", 32'(count), 32'd4);
      idle(2);
      chk("hold_head", 32'(out_data), 32'd1);
      chk("ovf_sticky", 32'(ovf), 32'd1);
      // push and pop together at full: only the pop proceeds
      out_ready = 1'b1;
      push(10'd6, 1'b0, 1'b0, 1'b0);
      chk("full_pushpop_count", 32'(count), 32'd3);
      idle(3);
      out_ready = 1'b0;
      chk("fill_drained_count", 32'(count), 32'd0);
      chk("fill_drained_valid", 32'(out_valid), 32'd0);

      // streaming across many pointer wraps
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(10'(i), i[0], i[1], 1'b1);
         chk("stream_count", 32'(count), 32'd1);
      end
      idle(1);
      out_ready = 1'b0;
      chk("stream_end_count", 32'(count), 32'd0);

      // reset mid-operation with handshakes active
      push(10'h111, 1'b0, 1'b0, 1'b1);
      push(10'h222, 1'b0, 1'b1, 1'b1);
      push(10'h333, 1'b1, 1'b0, 1'b1);
      reset     = 1'b0;
      exp_q.delete();
      in_valid  = 1'b1;
      in_data   = 10'h3FF;
      out_ready = 1'b1;
      idle(1);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
      push(10'h155, 1'b1, 1'b1, 1'b1);
      chk("midrst_head", 32'(out_data), 32'h155);
      chk("midrst_flags", 32'({out_pinf, out_pzero}), 32'd3);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;

      // statistics: 300 infinity words then 2 zero words
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 302; i++) begin
         push(10'(i), (i < 300), (i >= 300), 1'b1);
      end
      idle(1);
      out_ready = 1'b0;
      chk("stats_inf_cnt", 32'(inf_cnt), 32'(EXP_INF));
      chk("stats_zero_cnt", 32'(zero_cnt), 32'(EXP_ZERO));
      chk("stats_ovf", 32'(ovf), 32'd0);

      idle(2);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
